// File: rtl/inic_ram_pkg.sv
// -----------------------------------------------------------------------------
// inic_ram_pkg
// Shared types and constants for the RAM initialisation sequencer.
//   state_e : sequencer states (IDLE, RD, WR, DONE)
//   ROM_AW  : boot ROM address width
//   RAM_AW  : working RAM address width
// -----------------------------------------------------------------------------
package inic_ram_pkg;

    localparam int ROM_AW = 17;
    localparam int RAM_AW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage : inic_ram_pkg

// File: rtl/inic_ram_addr_cnt.sv
// -----------------------------------------------------------------------------
// inic_ram_addr_cnt
// Word index counter for the ROM-to-RAM copy.
//   clk     : system clock
//   reset   : synchronous active-high reset (clears the index)
//   clr_i   : synchronous clear to word 0
//   inc_i   : advance to the next word
//   idx_o   : current word index
//   tc_o    : terminal count, high when idx_o == WORDS-1
// -----------------------------------------------------------------------------
module inic_ram_addr_cnt
    import inic_ram_pkg::*;
#(
    parameter int unsigned WORDS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              inc_i,
    output logic [ROM_AW-1:0] idx_o,
    output logic              tc_o
);

    localparam logic [ROM_AW-1:0] LAST_IDX = ROM_AW'(WORDS - 1);

    logic [ROM_AW-1:0] idx_q;

    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            idx_q <= '0;
        end else if (inc_i) begin
            idx_q <= idx_q + ROM_AW'(1);
        end
    end

    assign idx_o = idx_q;
    assign tc_o  = (idx_q == LAST_IDX);

endmodule : inic_ram_addr_cnt

// File: rtl/fsm_inic_ram.sv
// -----------------------------------------------------------------------------
// fsm_inic_ram
// Copies WORDS words from the boot ROM into the working RAM (starting at
// RAM_BASE) after reset, then grants normal RAM reads.
//
// State table
//   state | meaning
//   IDLE  | waiting for a copy request
//   RD    | ROM read issued for word idx
//   WR    | ROM data valid, written to RAM_BASE+idx
//   DONE  | copy complete, holding while the request stays high
//
// Ports
//   clk            : system clock
//   reset          : synchronous active-high reset
//   do_it_inic_ram : level start request
//   rom_to_ram     : selects ROM data onto the RAM write-data bus
//   dir_rom        : ROM read address
//   rom_enable     : ROM read enable
//   dir_ram        : RAM address
//   w_ram_enable   : RAM write enable
//   r_ram_enable   : RAM read enable for normal operation
//
// Build option
//   INIC_RAM_AUTOSTART_EN : when defined, the copy starts from IDLE on its own
//                           while the copy-complete flag is still clear.
// -----------------------------------------------------------------------------
module fsm_inic_ram
    import inic_ram_pkg::*;
#(
    parameter int unsigned       WORDS    = 16,
    parameter logic [RAM_AW-1:0] RAM_BASE = 32'h0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              do_it_inic_ram,
    output logic              rom_to_ram,
    output logic [ROM_AW-1:0] dir_rom,
    output logic              rom_enable,
    output logic [RAM_AW-1:0] dir_ram,
    output logic              w_ram_enable,
    output logic              r_ram_enable
);

    state_e            state_q, state_d;
    logic              inited_q, inited_d;
    logic              rom_en_q;
    logic              wr_q;
    logic              r_ram_q;
    logic              cnt_clr;
    logic              cnt_inc;
    logic              cnt_tc;
    logic              start_req;
    logic [ROM_AW-1:0] idx;

    inic_ram_addr_cnt #(
        .WORDS (WORDS)
    ) u_addr_cnt (
        .clk   (clk),
        .reset (reset),
        .clr_i (cnt_clr),
        .inc_i (cnt_inc),
        .idx_o (idx),
        .tc_o  (cnt_tc)
    );

`ifdef INIC_RAM_AUTOSTART_EN
    assign start_req = do_it_inic_ram | ~inited_q;
`else
    assign start_req = do_it_inic_ram;
`endif

    always_comb begin
        state_d  = state_q;
        inited_d = inited_q;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_req) begin
                    state_d = RD;
                    cnt_clr = 1'b1;
                end
            end
            RD: begin
                state_d = WR;
            end
            WR: begin
                if (cnt_tc) begin
                    state_d  = DONE;
                    inited_d = 1'b1;
                end else begin
                    state_d = RD;
                    cnt_inc = 1'b1;
                end
            end
            DONE: begin
                if (!do_it_inic_ram) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Enables are registered from the next-state values so they change on the
    // same edge as the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            inited_q <= 1'b0;
            rom_en_q <= 1'b0;
            wr_q     <= 1'b0;
            r_ram_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            inited_q <= inited_d;
            rom_en_q <= (state_d == RD) || (state_d == WR);
            wr_q     <= (state_d == WR);
            r_ram_q  <= inited_d && ((state_d == IDLE) || (state_d == DONE));
        end
    end

    assign rom_enable   = rom_en_q;
    assign w_ram_enable = wr_q;
    assign rom_to_ram   = wr_q;
    assign r_ram_enable = r_ram_q;
    assign dir_rom      = idx;
    assign dir_ram      = RAM_BASE + RAM_AW'(idx);

endmodule : fsm_inic_ram

// File: tb/tb_fsm_inic_ram.sv
module tb_fsm_inic_ram;

`ifdef INIC_RAM_AUTOSTART_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        do_it;

    logic        a_rom_to_ram, a_rom_en, a_wr, a_rd;
    logic [16:0] a_dir_rom;
    logic [31:0] a_dir_ram;
    logic        b_rom_to_ram, b_rom_en, b_wr, b_rd;
    logic [16:0] b_dir_rom;
    logic [31:0] b_dir_ram;

    fsm_inic_ram #(.WORDS(16), .RAM_BASE(32'h0)) dut (
        .clk            (clk),
        .reset          (reset),
        .do_it_inic_ram (do_it),
        .rom_to_ram     (a_rom_to_ram),
        .dir_rom        (a_dir_rom),
        .rom_enable     (a_rom_en),
        .dir_ram        (a_dir_ram),
        .w_ram_enable   (a_wr),
        .r_ram_enable   (a_rd)
    );

    fsm_inic_ram #(.WORDS(1), .RAM_BASE(32'h100)) dut1 (
        .clk            (clk),
        .reset          (reset),
        .do_it_inic_ram (do_it),
        .rom_to_ram     (b_rom_to_ram),
        .dir_rom        (b_dir_rom),
        .rom_enable     (b_rom_en),
        .dir_ram        (b_dir_ram),
        .w_ram_enable   (b_wr),
        .r_ram_enable   (b_rd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a copy is "busy" for 2*W cycles counted by t; word t/2
    // is read on even t and written on odd t.
    int          m_w    [2] = '{16, 1};
    logic [31:0] m_base [2] = '{32'h0, 32'h100};
    bit          m_busy [2];
    bit          m_done [2];
    bit          m_init [2];
    int          m_t    [2];
    int          m_idx  [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic model_update(input bit rst_v, input bit req);
        for (int k = 0; k < 2; k++) begin
            if (rst_v) begin
                m_busy[k] = 0; m_done[k] = 0; m_init[k] = 0; m_t[k] = 0; m_idx[k] = 0;
            end else if (m_busy[k]) begin
                m_t[k]++;
                if (m_t[k] == 2 * m_w[k]) begin
                    m_busy[k] = 0; m_done[k] = 1; m_init[k] = 1;
                end else begin
                    m_idx[k] = m_t[k] / 2;
                end
            end else if (m_done[k]) begin
                if (!req) m_done[k] = 0;
            end else if (req || (AUTO && !m_init[k])) begin
                m_busy[k] = 1; m_t[k] = 0; m_idx[k] = 0;
            end
        end
    endtask

    task automatic compare_all();
        logic        e_en, e_wr, e_rd;
        logic [31:0] e_ram;
        for (int k = 0; k < 2; k++) begin
            e_en  = m_busy[k];
            e_wr  = m_busy[k] && (m_t[k] % 2 == 1);
            e_rd  = m_init[k] && !m_busy[k];
            e_ram = m_base[k] + 32'(m_idx[k]);
            if (k == 0) begin
                chk("a_rom_enable",   32'(a_rom_en),     32'(e_en));
                chk("a_w_ram_enable", 32'(a_wr),         32'(e_wr));
                chk("a_rom_to_ram",   32'(a_rom_to_ram), 32'(e_wr));
                chk("a_r_ram_enable", 32'(a_rd),         32'(e_rd));
                chk("a_dir_rom",      32'(a_dir_rom),    32'(m_idx[k]));
                chk("a_dir_ram",      a_dir_ram,         e_ram);
            end else begin
                chk("b_rom_enable",   32'(b_rom_en),     32'(e_en));
                chk("b_w_ram_enable", 32'(b_wr),         32'(e_wr));
                chk("b_rom_to_ram",   32'(b_rom_to_ram), 32'(e_wr));
                chk("b_r_ram_enable", 32'(b_rd),         32'(e_rd));
                chk("b_dir_rom",      32'(b_dir_rom),    32'(m_idx[k]));
                chk("b_dir_ram",      b_dir_ram,         e_ram);
            end
        end
    endtask

    task automatic step(input bit req, input bit rst_v);
        reset = rst_v;
        do_it = req;
        @(posedge clk);
        model_update(rst_v, req);
        #1;
        compare_all();
    endtask

    int a_writes;
    int b_writes;

    initial begin
        reset = 1'b1;
        do_it = 1'b1;

        // Reset held with the request high.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
        chk("rst_dir_rom", 32'(a_dir_rom), 32'h0);
        chk("rst_dir_ram_b", b_dir_ram, 32'h100);

        // Release with request high for 2 cycles, then low.
        a_writes = 0;
        b_writes = 0;
        for (int i = 1; i <= 42; i++) begin
            step(i <= 2, 1'b0);
            if (a_wr) begin
                chk("a_wr_addr_seq", a_dir_ram, 32'(a_writes));
                chk("a_wr_rom_eq_ram", 32'(a_dir_rom), a_dir_ram);
                a_writes++;
            end
            if (b_wr) begin
                chk("b_wr_addr", b_dir_ram, 32'h100);
                b_writes++;
            end
            if (i == 3)  chk("b_done_after_2", 32'(b_rd), 32'h1);
            if (i == 32) chk("a_rd_before_done", 32'(a_rd), 32'h0);
            if (i == 33) chk("a_rd_at_done", 32'(a_rd), 32'h1);
        end
        chk("a_write_count", 32'(a_writes), 32'd16);
        chk("b_write_count", 32'(b_writes), 32'd1);

        // Request held through a full repeat copy, then dropped.
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0);
        chk("a_hold_done_rd", 32'(a_rd), 32'h1);
        step(1'b0, 1'b0);
        chk("a_idle_rd_kept", 32'(a_rd), 32'h1);
        chk("a_idle_rom_en", 32'(a_rom_en), 32'h0);

        // Abort with reset on the 5th write.
        a_writes = 0;
        step(1'b1, 1'b0);
        for (int i = 0; i < 40 && a_writes < 5; i++) begin
            step(1'b0, 1'b0);
            if (a_wr) a_writes++;
        end
        chk("a_fifth_write_seen", 32'(a_writes), 32'd5);
        step(1'b0, 1'b1);
        chk("a_abort_rd", 32'(a_rd), 32'h0);
        chk("a_abort_dir_rom", 32'(a_dir_rom), 32'h0);

        // Restart and complete from word 0.
        a_writes = 0;
        step(1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b0);
            if (a_wr) begin
                chk("a_restart_addr", a_dir_ram, 32'(a_writes));
                a_writes++;
            end
        end
        chk("a_restart_count", 32'(a_writes), 32'd16);
        chk("a_restart_rd", 32'(a_rd), 32'h1);

        // Randomised request levels with occasional reset.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, $urandom_range(0, 59) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_fsm_inic_ram
